// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// Computes one bit per cycle (XLEN iterations) with a three-state FSM.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - M-extension instruction present in EX
//   funct3          - operation select (MUL..REMU)
//   op_a, op_b      - rs1 / rs2 values
//   flush           - squash the operation in progress
//   stall           - combinational pipeline hold
//   busy            - FSM not in IDLE
//   done            - one-cycle pulse, result valid
//   result          - registered result, held until the next accepted start
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_r;
    logic [2:0]        f3_r;
    logic              neg_r;
    logic [XLEN-1:0]   opnd_r;    // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_r;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]     cnt_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              special_s;
    logic [XLEN-1:0]   special_res_s;
    logic [XLEN:0]     mul_sum_s, div_trial_s, div_diff_s;
    logic [2*XLEN-1:0] acc_nxt_s, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, calc_res_s;

    // Operand decode at acceptance: signedness, magnitudes, result sign, special cases.
    always_comb begin
        a_signed_s = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed_s = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_s    = a_signed_s & op_a[XLEN-1];
        b_neg_s    = b_signed_s & op_b[XLEN-1];
        mag_a_s    = a_neg_s ? (~op_a + {{(XLEN-1){1'b0}}, 1'b1}) : op_a;
        mag_b_s    = b_neg_s ? (~op_b + {{(XLEN-1){1'b0}}, 1'b1}) : op_b;
        // Remainder follows the dividend; everything else follows the sign product.
        if (funct3 == 3'b110) begin
            neg_s = a_neg_s;
        end else begin
            neg_s = a_neg_s ^ b_neg_s;
        end
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
        if (funct3[2] && (op_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? op_a : ALL_ONES;
        end else if (((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                     (op_a == INT_MIN) && (op_b == ALL_ONES)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
        end else begin
            special_s     = 1'b0;
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration step plus the sign-corrected final result.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                      (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_trial_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_diff_s  = div_trial_s - {1'b0, opnd_r};
        if (f3_r[2]) begin
            // Restore when the trial subtraction goes negative.
            if (div_diff_s[XLEN]) begin
                acc_nxt_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
        prod_s = neg_r ? (~acc_nxt_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_nxt_s;
        quo_s  = acc_nxt_s[XLEN-1:0];
        rem_s  = acc_nxt_s[2*XLEN-1:XLEN];
        case (f3_r)
            3'b000:  calc_res_s = prod_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  calc_res_s = prod_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  calc_res_s = neg_r ? (~quo_s + {{(XLEN-1){1'b0}}, 1'b1}) : quo_s;
            3'b110,
            3'b111:  calc_res_s = neg_r ? (~rem_s + {{(XLEN-1){1'b0}}, 1'b1}) : rem_s;
            default: calc_res_s = {XLEN{1'b0}};
        endcase
    end

    // Sequencing FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            f3_r     <= 3'b000;
            neg_r    <= 1'b0;
            opnd_r   <= {XLEN{1'b0}};
            acc_r    <= {(2*XLEN){1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        f3_r  <= funct3;
                        neg_r <= neg_s;
                        cnt_r <= {CW{1'b0}};
                        if (special_s) begin
                            result_r <= special_res_s;
                            state_r  <= DONE;
                        end else begin
                            opnd_r  <= funct3[2] ? mag_b_s : mag_a_s;
                            acc_r   <= funct3[2] ? {{XLEN{1'b0}}, mag_a_s}
                                                 : {{XLEN{1'b0}}, mag_b_s};
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        result_r <= calc_res_s;
                        state_r  <= DONE;
                    end
                end
                DONE: begin
                    // The finished instruction is still in EX, so start is ignored.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign stall  = ~reset & (((state_r == IDLE) & start & ~flush) | (state_r == CALC));
    assign busy   = (state_r != IDLE);
    assign done   = (state_r == DONE);
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the stimulus process pushes the
// expected result and latency per accepted op; the monitor pops on done.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   stall_cnt = 0;
    int   op_id = 0;
    logic stall_clr_req = 1'b0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks each done against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (stall_clr_req) begin
                stall_cnt     = 0;
                stall_clr_req = 1'b0;
            end
            if (stall === 1'b1) stall_cnt++;
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("op%0d_result", e.id), result, e.res);
                    check($sformatf("op%0d_latency", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
                    check($sformatf("op%0d_stall_cycles", e.id), 32'(stall_cnt), 32'(e.lat));
                end
                stall_cnt = 0;
            end
        end
    end

    // Issue one op at posedge+1, hold start until done, then release one edge later.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        exp_t e;
        int   n;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        e.res = exp; e.start_cyc = cyc; e.lat = lat; e.id = op_id;
        op_id++;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 60);
        if (done !== 1'b1) begin
            total_cnt++;
            $display("FAIL op%0d_timeout: got no done expected done within 60 cycles", e.id);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int c;
        reset = 1'b1; start = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_reset", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clk); #1;

        // Multiply variants and normal divides, issued back to back.
        run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op(3'b111, 32'd100,      32'd7,        32'd2,         33);
        run_op(3'b101, 32'd100,      32'd7,        32'd14,        33);

        // Flush a DIV in cycle 10: no done, idle next cycle, result keeps 14.
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
        c = cyc;
        repeat (10) @(posedge clk);
        #1;
        check("flush_cycle_index", 32'(cyc - c), 32'd10);
        start = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; stall_clr_req = 1'b1;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_held", result, 32'd14);
        @(posedge clk); #1;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Reset in cycle 5 of a MUL.
        start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("midreset_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; stall_clr_req = 1'b1;
        @(posedge clk); #1;

        // Special division cases, done in cycle 1.
        run_op(3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op(3'b111, 32'd5,        32'd0,        32'd5,         1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
